// File: rtl/exception_ctrl.sv
// Exception sequencer for the single-cycle LEGv8 core: takes undefined-instruction,
// illegal-ERET and external-IRQ exceptions, selects the next PC and holds ELR/ESR/count.
module exception_ctrl #(
    parameter logic [63:0] VECTOR_ADDR = 64'h0000_0000_0000_00D8,
    parameter int          CNT_W       = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] PC,
    input  logic        NotAnInstr,
    input  logic        ERet,
    input  logic        ExtIRQ,
    input  logic [1:0]  SysRegSel,
    output logic [63:0] SysRegData,
    output logic [1:0]  PCSel,
    output logic        ExcTake,
    output logic        InHandler,
    output logic        Halt
);

    typedef enum logic [1:0] {
        NORMAL  = 2'd0,
        HANDLER = 2'd1,
        FAULT   = 2'd2
    } state_t;

    typedef enum logic [3:0] {
        CAUSE_NONE  = 4'b0000,
        CAUSE_UNDEF = 4'b0001,
        CAUSE_ERET  = 4'b0010,
        CAUSE_IRQ   = 4'b0011
    } cause_t;

    localparam logic [1:0] PC_SEQ = 2'b00;
    localparam logic [1:0] PC_VEC = 2'b01;
    localparam logic [1:0] PC_ELR = 2'b10;

    state_t           state;
    logic [63:0]      elr;
    logic [3:0]       esr;
    logic [CNT_W-1:0] count;
    logic             irq_pend;
    cause_t           cause;
    logic             irq_take;

    // The datapath loads VECTOR_ADDR on PCSel=01; LEGv8 fetch is word-aligned.
    vector_aligned: assert property (@(posedge clk) VECTOR_ADDR[1:0] == 2'b00);

    // Exception cause in NORMAL, highest priority first.
    always_comb begin
        // NOTE: every signal driven here gets a default first so no latch is inferred.
        cause = CAUSE_NONE;
        if (state == NORMAL) begin
            if (NotAnInstr)    cause = CAUSE_UNDEF;
            else if (ERet)     cause = CAUSE_ERET;
            else if (irq_pend) cause = CAUSE_IRQ;
        end
        irq_take = (cause == CAUSE_IRQ);
    end

    always_comb begin
        PCSel   = PC_SEQ;
        ExcTake = 1'b0;
        case (state)
            NORMAL: begin
                if (cause != CAUSE_NONE) begin
                    ExcTake = 1'b1;
                    PCSel   = PC_VEC;
                end
            end
            HANDLER: begin
                if (ERet)            PCSel   = PC_ELR;
                else if (NotAnInstr) ExcTake = 1'b1;
            end
            default: ;
        endcase
    end

    // MRS reads see register values from before the current edge.
    always_comb begin
        SysRegData = 64'd0;
        case (SysRegSel)
            2'b00:   SysRegData = elr;
            2'b01:   SysRegData = {60'd0, esr};
            2'b10:   SysRegData = 64'(count);
            default: SysRegData = {62'd0, state};
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so every read sees the pre-edge value.
        if (reset) begin
            state     <= NORMAL;
            elr       <= 64'd0;
            esr       <= 4'b0000;
            count     <= '0;
            irq_pend  <= 1'b0;
            InHandler <= 1'b0;
            Halt      <= 1'b0;
        end else begin
            // A request arriving on the same edge as a take stays pending.
            irq_pend <= ExtIRQ | (irq_pend & ~irq_take);
            case (state)
                NORMAL: begin
                    if (cause != CAUSE_NONE) begin
                        elr       <= PC;
                        esr       <= cause;
                        state     <= HANDLER;
                        InHandler <= 1'b1;
                        if (count != '1) count <= count + CNT_W'(1);
                    end
                end
                HANDLER: begin
                    if (ERet) begin
                        state     <= NORMAL;
                        InHandler <= 1'b0;
                    end else if (NotAnInstr) begin
                        state     <= FAULT;
                        InHandler <= 1'b0;
                        Halt      <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_exception_ctrl.sv
// Self-checking bench for exception_ctrl: directed vector table, multi-cycle corner
// sequences, then randomized traffic against a behavioural model.
module tb_exception_ctrl;

    localparam int          CNT_W   = 8;
    localparam logic [63:0] VEC     = 64'h0000_0000_0000_00D8;
    localparam logic [63:0] CNT_MAX = (64'd1 << CNT_W) - 64'd1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] pc = 64'd0;
    logic        nai = 1'b0;
    logic        eret = 1'b0;
    logic        irq = 1'b0;
    logic [1:0]  sel = 2'b00;
    logic [63:0] sys_data;
    logic [1:0]  pc_sel;
    logic        exc_take;
    logic        in_handler;
    logic        halt;

    int n_checks = 0;
    int n_fail   = 0;

    exception_ctrl #(
        .VECTOR_ADDR(VEC),
        .CNT_W      (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .PC        (pc),
        .NotAnInstr(nai),
        .ERet      (eret),
        .ExtIRQ    (irq),
        .SysRegSel (sel),
        .SysRegData(sys_data),
        .PCSel     (pc_sel),
        .ExcTake   (exc_take),
        .InHandler (in_handler),
        .Halt      (halt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rst;
        logic [63:0] pc;
        logic        nai;
        logic        eret;
        logic        irq;
        logic [1:0]  sel;
        logic [1:0]  pcsel;
        logic        exc;
        logic        inh;
        logic        halt;
        logic [63:0] data;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(input logic rst, input logic [63:0] p, input logic n, input logic e,
                               input logic i, input logic [1:0] s, input logic [1:0] ps,
                               input logic x, input logic h, input logic f, input logic [63:0] d);
        vec_t r;
        r.rst = rst; r.pc = p; r.nai = n; r.eret = e; r.irq = i; r.sel = s;
        r.pcsel = ps; r.exc = x; r.inh = h; r.halt = f; r.data = d;
        return r;
    endfunction

    // Behavioural model: mode 0 normal, 1 in handler, 2 halted.
    int          m_mode;
    logic [63:0] m_elr;
    logic [63:0] m_esr;
    logic [63:0] m_cnt;
    bit          m_pend;

    task automatic model_reset();
        m_mode = 0; m_elr = 64'd0; m_esr = 64'd0; m_cnt = 64'd0; m_pend = 1'b0;
    endtask

    task automatic cycle(input logic r, input logic [63:0] p, input logic n, input logic e,
                         input logic i, input logic [1:0] s, input string tag);
        int          c;
        logic [1:0]  e_pcsel;
        logic        e_exc;
        logic [63:0] e_data;
        reset = r; pc = p; nai = n; eret = e; irq = i; sel = s;
        #4;
        c = 0; e_pcsel = 2'd0; e_exc = 1'b0;
        if (m_mode == 0) begin
            c = n ? 1 : e ? 2 : m_pend ? 3 : 0;
            if (c != 0) begin e_exc = 1'b1; e_pcsel = 2'd1; end
        end else if (m_mode == 1) begin
            if (e) e_pcsel = 2'd2;
            else if (n) e_exc = 1'b1;
        end
        case (s)
            2'd0:    e_data = m_elr;
            2'd1:    e_data = m_esr;
            2'd2:    e_data = m_cnt;
            default: e_data = 64'(m_mode);
        endcase
        check({tag, " pcsel"}, 64'(pc_sel), 64'(e_pcsel));
        check({tag, " exctake"}, 64'(exc_take), 64'(e_exc));
        check({tag, " inhandler"}, 64'(in_handler), 64'(m_mode == 1));
        check({tag, " halt"}, 64'(halt), 64'(m_mode == 2));
        check({tag, " sysreg"}, sys_data, e_data);
        @(posedge clk);
        if (r) begin
            model_reset();
        end else begin
            if (m_mode == 0 && c != 0) begin
                m_elr = p; m_esr = 64'(c); m_mode = 1;
                if (m_cnt < CNT_MAX) m_cnt++;
                if (c == 3) m_pend = 1'b0;
            end else if (m_mode == 1 && e) begin
                m_mode = 0;
            end else if (m_mode == 1 && n) begin
                m_mode = 2;
            end
            if (i) m_pend = 1'b1;
        end
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time 0x%0h reached, expected finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        //            rst pc        nai eret irq sel   pcsel  exc inh halt data
        vecs.push_back(v(0, 64'h0,   0, 0, 0, 2'd0, 2'd0, 0, 0, 0, 64'h0));
        vecs.push_back(v(0, 64'h4,   0, 0, 0, 2'd1, 2'd0, 0, 0, 0, 64'h0));
        vecs.push_back(v(0, 64'h8,   0, 0, 0, 2'd2, 2'd0, 0, 0, 0, 64'h0));
        vecs.push_back(v(0, 64'hC,   0, 0, 0, 2'd3, 2'd0, 0, 0, 0, 64'h0));
        vecs.push_back(v(0, 64'h40,  1, 0, 0, 2'd0, 2'd1, 1, 0, 0, 64'h0));
        vecs.push_back(v(0, 64'hD8,  0, 0, 0, 2'd0, 2'd0, 0, 1, 0, 64'h40));
        vecs.push_back(v(0, 64'hDC,  0, 0, 0, 2'd1, 2'd0, 0, 1, 0, 64'h1));
        vecs.push_back(v(0, 64'hE0,  0, 0, 0, 2'd2, 2'd0, 0, 1, 0, 64'h1));
        vecs.push_back(v(0, 64'hE4,  0, 1, 0, 2'd3, 2'd2, 0, 1, 0, 64'h1));
        vecs.push_back(v(0, 64'h40,  0, 0, 0, 2'd0, 2'd0, 0, 0, 0, 64'h40));
        vecs.push_back(v(0, 64'h44,  0, 0, 0, 2'd3, 2'd0, 0, 0, 0, 64'h0));
        vecs.push_back(v(0, 64'h100, 0, 0, 1, 2'd2, 2'd0, 0, 0, 0, 64'h1));
        vecs.push_back(v(0, 64'h100, 0, 0, 0, 2'd0, 2'd1, 1, 0, 0, 64'h40));
        vecs.push_back(v(0, 64'hD8,  0, 0, 0, 2'd1, 2'd0, 0, 1, 0, 64'h3));
        vecs.push_back(v(0, 64'hDC,  0, 0, 0, 2'd2, 2'd0, 0, 1, 0, 64'h2));
        vecs.push_back(v(0, 64'hE0,  0, 1, 0, 2'd0, 2'd2, 0, 1, 0, 64'h100));
        vecs.push_back(v(0, 64'h100, 0, 0, 0, 2'd3, 2'd0, 0, 0, 0, 64'h0));
        vecs.push_back(v(0, 64'h200, 1, 0, 1, 2'd1, 2'd1, 1, 0, 0, 64'h3));
        vecs.push_back(v(0, 64'hD8,  0, 0, 0, 2'd1, 2'd0, 0, 1, 0, 64'h1));
        vecs.push_back(v(0, 64'hDC,  0, 0, 0, 2'd0, 2'd0, 0, 1, 0, 64'h200));
        vecs.push_back(v(0, 64'hE0,  0, 1, 0, 2'd2, 2'd2, 0, 1, 0, 64'h3));
        vecs.push_back(v(0, 64'h200, 0, 0, 0, 2'd1, 2'd1, 1, 0, 0, 64'h1));
        vecs.push_back(v(0, 64'hD8,  0, 0, 0, 2'd1, 2'd0, 0, 1, 0, 64'h3));
        vecs.push_back(v(0, 64'hDC,  0, 0, 0, 2'd2, 2'd0, 0, 1, 0, 64'h4));
        vecs.push_back(v(0, 64'hE0,  0, 1, 0, 2'd0, 2'd2, 0, 1, 0, 64'h200));
        vecs.push_back(v(0, 64'h20,  0, 1, 0, 2'd2, 2'd1, 1, 0, 0, 64'h4));
        vecs.push_back(v(0, 64'hD8,  0, 0, 0, 2'd0, 2'd0, 0, 1, 0, 64'h20));
        vecs.push_back(v(0, 64'hDC,  0, 0, 0, 2'd1, 2'd0, 0, 1, 0, 64'h2));
        vecs.push_back(v(0, 64'hE0,  0, 0, 0, 2'd2, 2'd0, 0, 1, 0, 64'h5));
        vecs.push_back(v(0, 64'hE4,  1, 0, 0, 2'd3, 2'd0, 1, 1, 0, 64'h1));
        vecs.push_back(v(0, 64'hE8,  0, 0, 0, 2'd3, 2'd0, 0, 0, 1, 64'h2));
        vecs.push_back(v(0, 64'hEC,  0, 1, 1, 2'd0, 2'd0, 0, 0, 1, 64'h20));
        vecs.push_back(v(0, 64'hF0,  1, 0, 0, 2'd1, 2'd0, 0, 0, 1, 64'h2));
        vecs.push_back(v(0, 64'hF4,  0, 0, 0, 2'd2, 2'd0, 0, 0, 1, 64'h5));
        vecs.push_back(v(1, 64'hF8,  0, 0, 0, 2'd2, 2'd0, 0, 0, 1, 64'h5));
        vecs.push_back(v(0, 64'h0,   0, 0, 0, 2'd2, 2'd0, 0, 0, 0, 64'h0));
        vecs.push_back(v(0, 64'h4,   0, 0, 0, 2'd3, 2'd0, 0, 0, 0, 64'h0));
        vecs.push_back(v(0, 64'h8,   0, 0, 0, 2'd0, 2'd0, 0, 0, 0, 64'h0));

        reset = 1'b1;
        @(posedge clk);
        #1;

        foreach (vecs[k]) begin
            reset = vecs[k].rst; pc = vecs[k].pc; nai = vecs[k].nai;
            eret = vecs[k].eret; irq = vecs[k].irq; sel = vecs[k].sel;
            #4;
            check($sformatf("vec%0d pcsel", k), 64'(pc_sel), 64'(vecs[k].pcsel));
            check($sformatf("vec%0d exctake", k), 64'(exc_take), 64'(vecs[k].exc));
            check($sformatf("vec%0d inhandler", k), 64'(in_handler), 64'(vecs[k].inh));
            check($sformatf("vec%0d halt", k), 64'(halt), 64'(vecs[k].halt));
            check($sformatf("vec%0d sysreg", k), sys_data, vecs[k].data);
            @(posedge clk);
            #1;
        end

        // The table ends in the post-reset state with nothing pending.
        model_reset();

        for (int k = 0; k < (1 << CNT_W) + 3; k++) begin
            cycle(1'b0, 64'h1000 + 64'(k) * 64'd4, 1'b1, 1'b0, 1'b0, 2'd2, "sat_exc");
            cycle(1'b0, VEC, 1'b0, 1'b1, 1'b0, 2'd2, "sat_ret");
        end
        reset = 1'b0; pc = 64'h2000; nai = 1'b0; eret = 1'b0; irq = 1'b0; sel = 2'd2;
        #4;
        check("count_saturated", sys_data, CNT_MAX);
        @(posedge clk);
        #1;

        // Reset while in the handler with an IRQ latched on the entry edge.
        cycle(1'b0, 64'h300, 1'b1, 1'b0, 1'b1, 2'd0, "rh_enter");
        cycle(1'b1, VEC, 1'b0, 1'b0, 1'b0, 2'd3, "rh_reset");
        reset = 1'b0; pc = 64'h0; nai = 1'b0; eret = 1'b0; irq = 1'b0; sel = 2'd0;
        #4;
        check("rh_inhandler", 64'(in_handler), 64'd0);
        check("rh_elr", sys_data, 64'd0);
        check("rh_irq_cleared", 64'(exc_take), 64'd0);
        @(posedge clk);
        #1;
        model_reset();

        for (int k = 0; k < 3000; k++) begin
            cycle(($urandom_range(0, 59) == 0),
                  {32'($urandom), 32'($urandom)},
                  ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 9) == 0),
                  2'($urandom_range(0, 3)),
                  $sformatf("rand%0d", k));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
